// File: rtl/frf_access_ctl_pkg.sv
// Shared constants, FSM encoding and SEC-DED (39,32) helpers for the FRF access controller.
// Codeword half layout: {ecc[6:0], data[31:0]}; Hamming positions 1..38, checks at powers of two.
package frf_access_ctl_pkg;

    localparam int FRF_ADDR_W  = 7;
    localparam int FRF_HALF_W  = 39;
    localparam int FRF_ECC_W   = 7;
    localparam int FRF_DATA_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_CHK   = 3'd3,
        ST_SCRUB = 3'd4
    } frf_state_e;

    function automatic logic is_check_pos(input logic [5:0] p);
        return (p & (p - 6'd1)) == 6'd0;
    endfunction

    // Data bit j sits at the j-th non-power-of-two position in 1..38.
    function automatic logic [FRF_ECC_W-1:0] secded_ecc(input logic [FRF_DATA_W-1:0] d);
        logic [FRF_ECC_W-1:0] e;
        logic [4:0]           j;
        e = '0;
        j = '0;
        for (logic [5:0] p = 6'd1; p <= 6'd38; p++) begin
            if (!is_check_pos(p)) begin
                for (logic [2:0] k = 3'd0; k < 3'd6; k++) begin
                    if (p[k]) e[k] = e[k] ^ d[j];
                end
                j = j + 5'd1;
            end
        end
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    function automatic logic [FRF_DATA_W-1:0] secded_fix(input logic [FRF_DATA_W-1:0] d,
                                                         input logic [5:0]            syn);
        logic [FRF_DATA_W-1:0] r;
        logic [4:0]            j;
        r = d;
        j = '0;
        for (logic [5:0] p = 6'd1; p <= 6'd38; p++) begin
            if (!is_check_pos(p)) begin
                if (syn == p) r[j] = ~r[j];
                j = j + 5'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frf_access_ctl_secded32.sv
// Combinational SEC-DED (39,32): re-encodes the data field of cw_i and checks/corrects cw_i.
// Module name frf_secded32 is shared by the write-path encoders and check-path decoders.
module frf_secded32
    import frf_access_ctl_pkg::*;
(
    input  logic [FRF_HALF_W-1:0] cw_i,
    output logic [FRF_HALF_W-1:0] cw_o,
    output logic [FRF_DATA_W-1:0] data_o,
    output logic                  ce_o,
    output logic                  ue_o
);

    logic [FRF_DATA_W-1:0] data;
    logic [FRF_ECC_W-1:0]  ecc_calc;
    logic [5:0]            syn;
    logic                  par;

    assign data     = cw_i[FRF_DATA_W-1:0];
    assign ecc_calc = secded_ecc(data);
    assign cw_o     = {ecc_calc, data};

    // A clean codeword has even parity over all 39 bits; odd parity means exactly one flip.
    assign syn    = ecc_calc[5:0] ^ cw_i[FRF_DATA_W +: 6];
    assign par    = ^cw_i;
    assign ce_o   = par;
    assign ue_o   = ~par & (syn != 6'd0);
    assign data_o = par ? secded_fix(data, syn) : data;

endmodule

// File: rtl/frf_access_ctl.sv
// FRF access controller: SEC-DED encoded writes, 4-cycle checked reads with one-cycle scrub of
// correctable halves, and saturating CE/UE counters.
module frf_access_ctl #(
    parameter int FRF_ADDR_W = frf_access_ctl_pkg::FRF_ADDR_W,
    parameter int CNT_W      = 8
) (
    input  logic                  rclk,
    input  logic                  arst_l,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [FRF_ADDR_W-1:0] req_addr,
    input  logic [1:0]            req_wmask,
    input  logic [63:0]           req_wdata,
    output logic [1:0]            ctl_frf_wen,
    output logic                  ctl_frf_ren,
    output logic [FRF_ADDR_W-1:0] ctl_frf_addr,
    output logic [77:0]           dp_frf_data,
    input  logic [77:0]           frf_dp_data,
    output logic                  rsp_vld,
    output logic [FRF_ADDR_W-1:0] rsp_addr,
    output logic [63:0]           rsp_data,
    output logic [1:0]            rsp_ce,
    output logic [1:0]            rsp_ue,
    output logic [CNT_W-1:0]      ce_cnt,
    output logic [CNT_W-1:0]      ue_cnt
);

    import frf_access_ctl_pkg::*;

    localparam int SUM_W = CNT_W + 1;

    frf_state_e            state_q, state_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [FRF_ADDR_W-1:0] rsp_addr_q, rsp_addr_d, rd_addr_q, rd_addr_d;
    logic [63:0]           rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_ce_q, rsp_ce_d, rsp_ue_q, rsp_ue_d;
    logic [CNT_W-1:0]      ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;

    logic [63:0]           wr_data;
    logic [FRF_HALF_W-1:0] enc_lo, enc_hi;
    logic [31:0]           chk_lo_data, chk_hi_data;
    logic                  chk_lo_ce, chk_lo_ue, chk_hi_ce, chk_hi_ue;
    logic [SUM_W-1:0]      ce_sum, ue_sum;
    logic                  accept;

    logic [31:0]           unused_wr_lo_data, unused_wr_hi_data;
    logic                  unused_wr_lo_ce, unused_wr_lo_ue, unused_wr_hi_ce, unused_wr_hi_ue;
    logic [FRF_HALF_W-1:0] unused_chk_lo_cw, unused_chk_hi_cw;

    // The write path encodes either the request data or the corrected read data during scrub.
    assign wr_data = (state_q == ST_SCRUB) ? rsp_data_q : req_wdata;

    frf_secded32 u_wr_lo (.cw_i({7'b0, wr_data[31:0]}), .cw_o(enc_lo), .data_o(unused_wr_lo_data),
                          .ce_o(unused_wr_lo_ce), .ue_o(unused_wr_lo_ue));
    frf_secded32 u_wr_hi (.cw_i({7'b0, wr_data[63:32]}), .cw_o(enc_hi), .data_o(unused_wr_hi_data),
                          .ce_o(unused_wr_hi_ce), .ue_o(unused_wr_hi_ue));
    frf_secded32 u_chk_lo (.cw_i(frf_dp_data[38:0]), .cw_o(unused_chk_lo_cw), .data_o(chk_lo_data),
                           .ce_o(chk_lo_ce), .ue_o(chk_lo_ue));
    frf_secded32 u_chk_hi (.cw_i(frf_dp_data[77:39]), .cw_o(unused_chk_hi_cw), .data_o(chk_hi_data),
                           .ce_o(chk_hi_ce), .ue_o(chk_hi_ue));

    // Gated by arst_l so nothing is accepted while reset is held.
    assign req_rdy = arst_l && (state_q == ST_IDLE);
    assign accept  = req_vld && req_rdy;

    assign ce_sum = {1'b0, ce_cnt_q} + SUM_W'(chk_lo_ce) + SUM_W'(chk_hi_ce);
    assign ue_sum = {1'b0, ue_cnt_q} + SUM_W'(chk_lo_ue) + SUM_W'(chk_hi_ue);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        rsp_vld_d    = 1'b0;
        rsp_addr_d   = rsp_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_ce_d     = rsp_ce_q;
        rsp_ue_d     = rsp_ue_q;
        ce_cnt_d     = ce_cnt_q;
        ue_cnt_d     = ue_cnt_q;
        ctl_frf_wen  = 2'b00;
        ctl_frf_ren  = 1'b0;
        ctl_frf_addr = '0;
        dp_frf_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && req_wr && (req_wmask != 2'b00)) begin
                    ctl_frf_wen  = req_wmask;
                    ctl_frf_addr = req_addr;
                    dp_frf_data  = {enc_hi, enc_lo};
                end else if (accept && !req_wr) begin
                    ctl_frf_ren  = 1'b1;
                    ctl_frf_addr = req_addr;
                    rd_addr_d    = req_addr;
                    state_d      = ST_RD1;
                end
            end
            ST_RD1: state_d = ST_RD2;
            ST_RD2: state_d = ST_CHK;
            ST_CHK: begin
                rsp_vld_d  = 1'b1;
                rsp_addr_d = rd_addr_q;
                rsp_data_d = {chk_hi_data, chk_lo_data};
                rsp_ce_d   = {chk_hi_ce, chk_lo_ce};
                rsp_ue_d   = {chk_hi_ue, chk_lo_ue};
                ce_cnt_d   = ce_sum[CNT_W] ? '1 : ce_sum[CNT_W-1:0];
                ue_cnt_d   = ue_sum[CNT_W] ? '1 : ue_sum[CNT_W-1:0];
                // Uncorrectable data is never written back, even if the other half was correctable.
                state_d    = ((chk_lo_ce || chk_hi_ce) && !(chk_lo_ue || chk_hi_ue)) ? ST_SCRUB : ST_IDLE;
            end
            ST_SCRUB: begin
                ctl_frf_wen  = rsp_ce_q;
                ctl_frf_addr = rsp_addr_q;
                dp_frf_data  = {enc_hi, enc_lo};
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_ce_q   <= 2'b00;
            rsp_ue_q   <= 2'b00;
            ce_cnt_q   <= '0;
            ue_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_ce_q   <= rsp_ce_d;
            rsp_ue_q   <= rsp_ue_d;
            ce_cnt_q   <= ce_cnt_d;
            ue_cnt_q   <= ue_cnt_d;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_addr = rsp_addr_q;
    assign rsp_data = rsp_data_q;
    assign rsp_ce   = rsp_ce_q;
    assign rsp_ue   = rsp_ue_q;
    assign ce_cnt   = ce_cnt_q;
    assign ue_cnt   = ue_cnt_q;

endmodule

// File: tb/tb_frf_access_ctl.sv
// Self-checking bench for frf_access_ctl: behavioural FRF with read-side error injection,
// a shadow of written data, and a textbook Hamming encoder as the reference.
module tb_frf_access_ctl;

    logic        rclk;
    logic        arst_l;
    logic        req_vld, req_rdy, req_wr;
    logic [6:0]  req_addr;
    logic [1:0]  req_wmask;
    logic [63:0] req_wdata;
    logic [1:0]  ctl_frf_wen;
    logic        ctl_frf_ren;
    logic [6:0]  ctl_frf_addr;
    logic [77:0] dp_frf_data;
    logic [77:0] frf_dp_data;
    logic        rsp_vld;
    logic [6:0]  rsp_addr;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_ce, rsp_ue;
    logic [7:0]  ce_cnt, ue_cnt;

    frf_access_ctl #(.FRF_ADDR_W(7), .CNT_W(8)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wmask(req_wmask), .req_wdata(req_wdata),
        .ctl_frf_wen(ctl_frf_wen), .ctl_frf_ren(ctl_frf_ren), .ctl_frf_addr(ctl_frf_addr),
        .dp_frf_data(dp_frf_data), .frf_dp_data(frf_dp_data),
        .rsp_vld(rsp_vld), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_ce(rsp_ce), .rsp_ue(rsp_ue), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Behavioural FRF: two-stage read pipe, per-half write enables, injected flips on read.
    logic [77:0] frf_mem [128];
    logic [77:0] frf_stage;
    logic [38:0] inj_lo, inj_hi;

    always @(posedge rclk) begin
        if (ctl_frf_wen[0]) frf_mem[ctl_frf_addr][38:0]  <= dp_frf_data[38:0];
        if (ctl_frf_wen[1]) frf_mem[ctl_frf_addr][77:39] <= dp_frf_data[77:39];
        if (ctl_frf_ren)    frf_stage <= frf_mem[ctl_frf_addr] ^ {inj_hi, inj_lo};
        frf_dp_data <= frf_stage;
    end

    int          total = 0;
    int          bad   = 0;
    int          ce_m  = 0;
    int          ue_m  = 0;
    logic [63:0] shadow [128];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Textbook Hamming placement: build the 38-position word, then parity over each position group.
    function automatic logic [38:0] m_enc(input logic [31:0] d);
        logic [38:0] pos;
        logic [6:0]  e;
        int          j;
        pos = '0;
        j   = 0;
        for (int p = 1; p <= 38; p++) begin
            if ($countones(p) != 1) begin
                pos[p] = d[j];
                j++;
            end
        end
        e = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if ((p >> k) % 2 == 1) e[k] = e[k] ^ pos[p];
        e[6] = (^d) ^ (^e[5:0]);
        return {e, d};
    endfunction

    function automatic int sat_add(input int c, input int n);
        return (c + n > 255) ? 255 : c + n;
    endfunction

    function automatic logic [38:0] rand_flips(input int n);
        logic [38:0] m;
        int          b1;
        m = '0;
        b1 = $urandom_range(0, 38);
        if (n >= 1) m[b1] = 1'b1;
        if (n >= 2) m[(b1 + $urandom_range(1, 38)) % 39] = 1'b1;
        return m;
    endfunction

    task automatic do_write(input logic [6:0] a, input logic [1:0] m, input logic [63:0] d,
                            input bit chk);
        logic [77:0] exp_dp;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wmask = m; req_wdata = d;
        exp_dp = (m != 2'b00) ? {m_enc(d[63:32]), m_enc(d[31:0])} : 78'd0;
        @(negedge rclk);
        if (chk) begin
            check("wr_rdy",  128'(req_rdy), 128'(1'b1));
            check("wr_wen",  128'(ctl_frf_wen), 128'(m));
            check("wr_ren",  128'(ctl_frf_ren), 128'(1'b0));
            check("wr_addr", 128'(ctl_frf_addr), 128'((m != 2'b00) ? a : 7'd0));
            check("wr_data", 128'(dp_frf_data), 128'(exp_dp));
        end
        @(posedge rclk); #1;
        req_vld = 1'b0;
        if (m[0]) shadow[a][31:0]  = d[31:0];
        if (m[1]) shadow[a][63:32] = d[63:32];
    endtask

    task automatic do_read(input logic [6:0] a, input logic [38:0] ml, input logic [38:0] mh);
        logic [1:0]  exp_ce, exp_ue;
        logic [63:0] exp_data;
        bit          scrub, seen;
        int          lat;
        exp_ce   = {$countones(mh) == 1, $countones(ml) == 1};
        exp_ue   = {$countones(mh) == 2, $countones(ml) == 2};
        exp_data = shadow[a];
        if (exp_ue[0]) exp_data[31:0]  = exp_data[31:0]  ^ ml[31:0];
        if (exp_ue[1]) exp_data[63:32] = exp_data[63:32] ^ mh[31:0];
        scrub = (exp_ce != 2'b00) && (exp_ue == 2'b00);
        ce_m  = sat_add(ce_m, $countones(exp_ce));
        ue_m  = sat_add(ue_m, $countones(exp_ue));

        inj_lo = ml; inj_hi = mh;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
        @(negedge rclk);
        check("rd_rdy",  128'(req_rdy), 128'(1'b1));
        check("rd_ren",  128'(ctl_frf_ren), 128'(1'b1));
        check("rd_wen",  128'(ctl_frf_wen), 128'(2'b00));
        check("rd_addr", 128'(ctl_frf_addr), 128'(a));
        @(posedge rclk); #1;
        req_vld = 1'b0;

        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge rclk);
            if (rsp_vld === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("rsp_latency", 128'(lat), 128'(4));
        check("rsp_addr",    128'(rsp_addr), 128'(a));
        check("rsp_data",    128'(rsp_data), 128'(exp_data));
        check("rsp_ce",      128'(rsp_ce), 128'(exp_ce));
        check("rsp_ue",      128'(rsp_ue), 128'(exp_ue));
        check("ce_cnt",      128'(ce_cnt), 128'(ce_m));
        check("ue_cnt",      128'(ue_cnt), 128'(ue_m));
        check("scrub_wen",   128'(ctl_frf_wen), 128'(scrub ? exp_ce : 2'b00));
        check("scrub_ren",   128'(ctl_frf_ren), 128'(1'b0));
        check("scrub_addr",  128'(ctl_frf_addr), 128'(scrub ? a : 7'd0));
        check("scrub_data",  128'(dp_frf_data),
              128'(scrub ? {m_enc(shadow[a][63:32]), m_enc(shadow[a][31:0])} : 78'd0));
        check("rsp_rdy",     128'(req_rdy), 128'(!scrub));
        @(posedge rclk); #1;
        @(negedge rclk);
        check("post_rsp_vld", 128'(rsp_vld), 128'(1'b0));
        check("post_rdy",     128'(req_rdy), 128'(1'b1));
        check("post_wen",     128'(ctl_frf_wen), 128'(2'b00));
        @(posedge rclk); #1;
        inj_lo = '0; inj_hi = '0;
    endtask

    initial begin
        bit          any_bad;
        int          guard;
        logic [38:0] ml, mh;

        arst_l = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wmask = '0; req_wdata = '0; inj_lo = '0; inj_hi = '0;

        // Reset values.
        repeat (2) @(posedge rclk);
        #2;
        check("rst_rdy",      128'(req_rdy), 128'(1'b0));
        check("rst_rsp_vld",  128'(rsp_vld), 128'(1'b0));
        check("rst_rsp_data", 128'(rsp_data), 128'(64'd0));
        check("rst_wen",      128'(ctl_frf_wen), 128'(2'b00));
        check("rst_ren",      128'(ctl_frf_ren), 128'(1'b0));
        check("rst_dp",       128'(dp_frf_data), 128'(78'd0));
        check("rst_cnt",      128'({ce_cnt, ue_cnt}), 128'(16'd0));
        @(posedge rclk); #1;
        arst_l = 1'b1;
        @(negedge rclk);
        check("rdy_after_rst", 128'(req_rdy), 128'(1'b1));
        @(posedge rclk); #1;

        for (int i = 0; i < 128; i++)
            do_write(7'(i), 2'b11, {$urandom, $urandom}, 1'b0);

        // All-zero write and clean read-back.
        do_write(7'd5, 2'b11, 64'd0, 1'b1);
        check("zero_codeword", 128'(m_enc(32'd0)), 128'(39'd0));
        do_read(7'd5, 39'd0, 39'd0);

        // Single flip of lo data bit 0, then a double flip in the hi half.
        do_write(7'd9, 2'b11, {$urandom, $urandom}, 1'b1);
        do_read(7'd9, 39'h1, 39'd0);
        do_read(7'd9, 39'd0, (39'd1 << 3) | (39'd1 << 20));
        do_read(7'd9, 39'd0, 39'd0);

        // Empty mask and hi-only mask.
        do_write(7'd20, 2'b00, {$urandom, $urandom}, 1'b1);
        do_write(7'd21, 2'b10, {$urandom, $urandom}, 1'b1);
        do_write(7'd22, 2'b01, {$urandom, $urandom}, 1'b1);
        do_read(7'd20, 39'd0, 39'd0);
        do_read(7'd21, 39'd0, 39'd0);
        do_read(7'd22, 39'd0, 39'd0);

        // Reset while the read sits in RD2: no response, no write, ready right after release.
        inj_lo = 39'h4;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'd33;
        @(posedge rclk); #1;
        req_vld = 1'b0;
        @(posedge rclk); #1;
        arst_l = 1'b0;
        #2;
        check("mid_rst_rdy", 128'(req_rdy), 128'(1'b0));
        check("mid_rst_vld", 128'(rsp_vld), 128'(1'b0));
        check("mid_rst_wen", 128'(ctl_frf_wen), 128'(2'b00));
        @(posedge rclk); #1;
        arst_l = 1'b1;
        ce_m = 0; ue_m = 0;
        @(negedge rclk);
        check("mid_rst_rdy_release", 128'(req_rdy), 128'(1'b1));
        any_bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            if (rsp_vld !== 1'b0 || ctl_frf_wen !== 2'b00) any_bad = 1'b1;
        end
        check("mid_rst_quiet", 128'(any_bad), 128'(1'b0));
        check("mid_rst_cnt",   128'({ce_cnt, ue_cnt}), 128'(16'd0));
        @(posedge rclk); #1;
        inj_lo = '0;

        // Random mix of writes and reads with 0/1/2 flips per half.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
                         {$urandom, $urandom}, 1'b1);
            end else begin
                ml = rand_flips($urandom_range(0, 2));
                mh = rand_flips($urandom_range(0, 2));
                do_read(7'($urandom_range(0, 127)), ml, mh);
            end
        end

        // Drive the CE counter to saturation, then one more CE must leave it at all-ones.
        guard = 0;
        while (ce_m < 255 && guard < 200) begin
            do_read(7'($urandom_range(0, 127)), rand_flips(1), rand_flips(1));
            guard++;
        end
        do_read(7'd9, 39'h1, 39'd0);
        check("ce_cnt_saturated", 128'(ce_cnt), 128'(8'hff));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frf_access_ctl.md
FRF_ACCESS_CTL -- requirements
Module: frf_access_ctl

Interface
REQ-001 Parameter FRF_ADDR_W, default 7, FRF entry address width (128 entries).
REQ-002 Parameter CNT_W, default 8, width of the saturating error counters.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 rclk  in  1  sole clock, rising edge.
REQ-005 arst_l  in  1  asynchronous active-low reset.
REQ-006 req_vld  in  1 / req_rdy  out  1  request handshake; transfer when both are high.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  7  FRF entry; req_wmask  in  2  half-write enables [1]=hi, [0]=lo; req_wdata  in  64  write data.
REQ-009 ctl_frf_wen  out  2 / ctl_frf_ren  out  1 / ctl_frf_addr  out  7 / dp_frf_data  out  78  FRF port drive.
REQ-010 frf_dp_data  in  78  FRF read data, valid 2 cycles after ctl_frf_ren.
REQ-011 rsp_vld  out  1 / rsp_addr  out  7 / rsp_data  out  64 / rsp_ce  out  2 / rsp_ue  out  2  read response; no backpressure.
REQ-012 ce_cnt, ue_cnt  out  CNT_W  saturating error counters.

Function
REQ-013 Codeword layout SHALL be half h = {ecc[6:0], data[31:0]}: lo half in bits [38:0], hi half in bits [77:39]; hi data is req_wdata[63:32].
REQ-014 ECC SHALL be Hamming SEC-DED (39,32): data occupies the non-power-of-two positions 3,5,6,7,9,... of positions 1..38 in ascending order; ecc[k] (k=0..5) = XOR of data bits whose position has bit k set; ecc[6] = XOR of all data bits and ecc[5:0].
REQ-015 Check: s = recomputed ecc[5:0] XOR stored; p = overall parity. s=0,p=0 clean; p=1 CE (flip position s; s=0 means ecc[6]); s!=0,p=0 UE.
REQ-016 FSM states SHALL be IDLE, RD1, RD2, CHK, SCRUB; req_rdy=1 only in IDLE.
REQ-017 IDLE, accepted write: same cycle, ctl_frf_wen=req_wmask, ctl_frf_addr=req_addr, dp_frf_data=encoded data; stay IDLE; back-to-back writes allowed.
REQ-018 Write with req_wmask=0 SHALL be accepted with no FRF access.
REQ-019 IDLE, accepted read: same cycle ctl_frf_ren=1, wen=0; then RD1 -> RD2 -> CHK.
REQ-020 CHK samples frf_dp_data (registered by the FRF); next cycle rsp_vld=1 for one cycle with corrected rsp_data, rsp_addr, and per-half rsp_ce/rsp_ue.
REQ-021 CHK with any CE and no UE -> SCRUB; otherwise -> IDLE.
REQ-022 SCRUB: one cycle, ctl_frf_wen = CE halves only, dp_frf_data = re-encoded corrected data, same address; then IDLE.
REQ-023 UE data SHALL be returned uncorrected and SHALL NOT be scrubbed.
REQ-024 ce_cnt += number of CE halves, ue_cnt += number of UE halves, per response; each saturates at all-ones.
REQ-025 ctl_frf_ren and ctl_frf_wen SHALL never be asserted together; all FRF outputs are 0 when idle.
REQ-026 Read-to-response latency SHALL be 4 cycles (acceptance at T, rsp_vld at T+4); throughput is 1 read per 4 cycles (5 with scrub).

Reset
REQ-027 On arst_l low: FSM=IDLE, req_rdy=0, rsp_vld=0, rsp_* = 0, FRF outputs = 0, counters = 0.
REQ-028 req_rdy SHALL rise in the first cycle after arst_l deasserts.
REQ-029 Reset mid-read or mid-scrub SHALL drop the operation with no response and no write.

Structure
REQ-030 FRF_ADDR_W, FRF_HALF_W=39, FRF_ECC_W=7 and the state encodings SHALL live in the shared define header.
REQ-031 One sub-module, frf_secded32 (encode + syndrome/correct, combinational), SHALL be instantiated once per half on the write path and once per half on the check path.

Verification
REQ-032 Write addr 5, mask 2'b11, data 0 -> wen=11 same cycle, dp_frf_data = 0; read addr 5 -> rsp at T+4, data 0, ce=ue=0.
REQ-033 Read addr 9, model returns lo half with data bit 0 flipped -> rsp_data corrected, rsp_ce=01, SCRUB writes wen=01 with clean codeword, ce_cnt=1.
REQ-034 Read with two bit flips in hi half -> rsp_ue=10, no SCRUB, ue_cnt=1, rsp_data hi half returned uncorrected.
REQ-035 Write mask 2'b00 -> req accepted, wen stays 00; write mask 2'b10 -> only hi half driven.
REQ-036 Force ce_cnt to 255, inject CE -> ce_cnt remains 255.
REQ-037 Assert arst_l low in RD2 -> no rsp_vld, no write; req_rdy=1 in the first cycle after release.
